video_frame_sig: RTL and testbench

VIDEO_FRAME_SIG -- requirements
Module: video_frame_sig

---
 rtl/video_frame_sig_if.sv | 32 +++
 rtl/video_frame_sig.sv | 164 ++++++++++++++++
 tb/tb_video_frame_sig.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/video_frame_sig_if.sv
// Video sample bus from the generator plus the per-frame signature results.
// The generator/bench side uses master, the signature block uses slave.
interface video_frame_sig_if #(
    parameter int CNT_W  = 12,
    parameter int FCNT_W = 16
);
    logic              ce_pix;
    logic [7:0]        VGA_R;
    logic [7:0]        VGA_G;
    logic [7:0]        VGA_B;
    logic              VGA_HS;
    logic              VGA_VS;
    logic              VGA_HB;
    logic              VGA_VB;

    logic              frame_valid;
    logic [31:0]       frame_crc;
    logic [CNT_W-1:0]  active_w;
    logic [CNT_W-1:0]  active_h;
    logic              width_err;
    logic [FCNT_W-1:0] frame_count;

    modport master (
        output ce_pix, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_HB, VGA_VB,
        input  frame_valid, frame_crc, active_w, active_h, width_err, frame_count
    );

    modport slave (
        input  ce_pix, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_HB, VGA_VB,
        output frame_valid, frame_crc, active_w, active_h, width_err, frame_count
    );
endinterface

// File: rtl/video_frame_sig.sv
// Per-frame video signature: CRC-32 over active pixels plus active width/height
// and a line-width consistency flag, published once per vertical blank.
module video_frame_sig #(
    parameter int CNT_W  = 12,
    parameter int FCNT_W = 16
) (
    input logic              clk_sys,
    input logic              reset_n,
    video_frame_sig_if.slave vid
);
    typedef enum logic {SEEK, ACTIVE} state_e;

    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_POLY = 32'h04C11DB7;

    state_e            state_q, state_d;
    logic              hbPrev_q, hbPrev_d;
    logic              vbPrev_q, vbPrev_d;
    logic [31:0]       crc_q, crc_d;
    logic [CNT_W-1:0]  lineCnt_q, lineCnt_d;
    logic [CNT_W-1:0]  lineTot_q, lineTot_d;
    logic [CNT_W-1:0]  refW_q, refW_d;
    logic              mismatch_q, mismatch_d;
    logic              outValid_q, outValid_d;
    logic [31:0]       outCrc_q, outCrc_d;
    logic [CNT_W-1:0]  outW_q, outW_d;
    logic [CNT_W-1:0]  outH_q, outH_d;
    logic              outErr_q, outErr_d;
    logic [FCNT_W-1:0] frameCnt_q, frameCnt_d;

    logic              hbRise, vbRise, activePix;
    logic [CNT_W-1:0]  wClose, hClose;
    logic              errClose;
    logic              unusedSyncs;

    function automatic logic [31:0] crcStep(input logic [31:0] c, input logic [23:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 23; i >= 0; i--) begin
            if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ CRC_POLY;
            else              r = {r[30:0], 1'b0};
        end
        return r;
    endfunction

    assign hbRise    = vid.ce_pix & vid.VGA_HB & ~hbPrev_q;
    assign vbRise    = vid.ce_pix & vid.VGA_VB & ~vbPrev_q;
    assign activePix = vid.ce_pix & ~vid.VGA_HB & ~vid.VGA_VB;

    // Accumulator values as they would be after closing the open line.
    always_comb begin
        hClose   = lineTot_q;
        wClose   = refW_q;
        errClose = mismatch_q;
        if (lineCnt_q != '0) begin
            if (lineTot_q != '1) hClose = lineTot_q + CNT_W'(1);
            if (lineTot_q == '0)            wClose   = lineCnt_q;
            else if (lineCnt_q != refW_q)   errClose = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        hbPrev_d   = hbPrev_q;
        vbPrev_d   = vbPrev_q;
        crc_d      = crc_q;
        lineCnt_d  = lineCnt_q;
        lineTot_d  = lineTot_q;
        refW_d     = refW_q;
        mismatch_d = mismatch_q;
        outValid_d = 1'b0;
        outCrc_d   = outCrc_q;
        outW_d     = outW_q;
        outH_d     = outH_q;
        outErr_d   = outErr_q;
        frameCnt_d = frameCnt_q;

        if (vid.ce_pix) begin
            hbPrev_d = vid.VGA_HB;
            vbPrev_d = vid.VGA_VB;
            unique case (state_q)
                SEEK: begin
                    if (vbRise) begin
                        state_d    = ACTIVE;
                        crc_d      = CRC_INIT;
                        lineCnt_d  = '0;
                        lineTot_d  = '0;
                        refW_d     = '0;
                        mismatch_d = 1'b0;
                    end
                end
                ACTIVE: begin
                    if (vbRise) begin
                        outValid_d = 1'b1;
                        outCrc_d   = crc_q;
                        outW_d     = wClose;
                        outH_d     = hClose;
                        outErr_d   = errClose;
                        frameCnt_d = frameCnt_q + FCNT_W'(1);
                        crc_d      = CRC_INIT;
                        lineCnt_d  = '0;
                        lineTot_d  = '0;
                        refW_d     = '0;
                        mismatch_d = 1'b0;
                    end else if (hbRise) begin
                        // With an empty line the close values equal the current ones.
                        lineTot_d  = hClose;
                        refW_d     = wClose;
                        mismatch_d = errClose;
                        lineCnt_d  = '0;
                    end else if (activePix) begin
                        crc_d = crcStep(crc_q, {vid.VGA_R, vid.VGA_G, vid.VGA_B});
                        if (lineCnt_q != '1) lineCnt_d = lineCnt_q + CNT_W'(1);
                    end
                end
                default: state_d = SEEK;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q    <= SEEK;
            hbPrev_q   <= 1'b1;
            vbPrev_q   <= 1'b1;
            crc_q      <= CRC_INIT;
            lineCnt_q  <= '0;
            lineTot_q  <= '0;
            refW_q     <= '0;
            mismatch_q <= 1'b0;
            outValid_q <= 1'b0;
            outCrc_q   <= '0;
            outW_q     <= '0;
            outH_q     <= '0;
            outErr_q   <= 1'b0;
            frameCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hbPrev_q   <= hbPrev_d;
            vbPrev_q   <= vbPrev_d;
            crc_q      <= crc_d;
            lineCnt_q  <= lineCnt_d;
            lineTot_q  <= lineTot_d;
            refW_q     <= refW_d;
            mismatch_q <= mismatch_d;
            outValid_q <= outValid_d;
            outCrc_q   <= outCrc_d;
            outW_q     <= outW_d;
            outH_q     <= outH_d;
            outErr_q   <= outErr_d;
            frameCnt_q <= frameCnt_d;
        end
    end

    assign vid.frame_valid = outValid_q;
    assign vid.frame_crc   = outCrc_q;
    assign vid.active_w    = outW_q;
    assign vid.active_h    = outH_q;
    assign vid.width_err   = outErr_q;
    assign vid.frame_count = frameCnt_q;

    // Syncs are part of the bus but framing relies on the blanks only.
    assign unusedSyncs = vid.VGA_HS ^ vid.VGA_VS;
endmodule

// File: tb/tb_video_frame_sig.sv
// Directed bench for video_frame_sig: a table of frame shapes checked against
// a byte-wise CRC model, plus hand sequences for reset and a known CRC value.
module tb_video_frame_sig;
    logic clk_sys;
    logic reset_n;

    video_frame_sig_if vid ();

    video_frame_sig dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .vid     (vid.slave)
    );

    typedef struct {
        int lines;
        int w0;
        int w1;
        int w2;
        bit gap;
        bit flip;
        bit joinVb;
        int expW;
        int expH;
        bit expErr;
    } frameVec_t;

    int          checks;
    int          failures;
    int          pubCount;
    int          expCount;
    logic [31:0] refCrc;
    logic [31:0] crcM;
    frameVec_t   vecs[9];

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    function automatic logic [31:0] modelCrc(input logic [31:0] c, input logic [23:0] px);
        logic [31:0] r;
        logic [7:0]  byteV;
        r = c;
        for (int b = 2; b >= 0; b--) begin
            byteV = px[b*8 +: 8];
            r = r ^ {byteV, 24'h0};
            for (int k = 0; k < 8; k++)
                r = r[31] ? ((r << 1) ^ 32'h04C11DB7) : (r << 1);
        end
        return r;
    endfunction

    function automatic logic [23:0] pixVal(input int p, input bit flip);
        logic [7:0] r, g, b;
        r = 8'(p * 7 + 1);
        g = 8'(p * 13 + 2);
        b = 8'(p * 29 + 3);
        if (flip) r[0] = ~r[0];
        return {r, g, b};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic checkDiffer(input string name, input logic [31:0] act, input logic [31:0] notExp);
        checks++;
        if (act === notExp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=not %h", name, act, notExp);
        end
    endtask

    task automatic applyStimulus(input logic ce, input logic hb, input logic vb, input logic [23:0] px);
        vid.ce_pix = ce;
        vid.VGA_HB = hb;
        vid.VGA_VB = vb;
        vid.VGA_HS = hb;
        vid.VGA_VS = vb;
        vid.VGA_R  = px[23:16];
        vid.VGA_G  = px[15:8];
        vid.VGA_B  = px[7:0];
        @(posedge clk_sys);
        #1;
        if (vid.frame_valid === 1'b1) pubCount++;
    endtask

    // A gap cycle carries junk blanks/pixels that must be ignored without ce_pix.
    task automatic sendPixel(input logic [23:0] px, input bit gap);
        logic [31:0] r;
        applyStimulus(1'b1, 1'b0, 1'b0, px);
        if (gap) begin
            r = $urandom;
            applyStimulus(1'b0, r[0], r[1], r[25:2]);
        end
    endtask

    task automatic blankTail();
        applyStimulus(1'b1, 1'b1, 1'b1, 24'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 24'h0);
    endtask

    task automatic alignFrame(input string tag);
        applyStimulus(1'b1, 1'b1, 1'b1, 24'h0);
        checkOutput({tag, "_align_no_valid"}, 32'(vid.frame_valid), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 24'h0);
        blankTail();
    endtask

    task automatic endFrame(input string tag, input logic [31:0] eCrc, input int eW, input int eH, input bit eErr);
        applyStimulus(1'b1, 1'b1, 1'b1, 24'h0);
        expCount++;
        checkOutput({tag, "_valid"}, 32'(vid.frame_valid), 32'd1);
        checkOutput({tag, "_crc"},   vid.frame_crc, eCrc);
        checkOutput({tag, "_w"},     32'(vid.active_w), 32'(eW));
        checkOutput({tag, "_h"},     32'(vid.active_h), 32'(eH));
        checkOutput({tag, "_err"},   32'(vid.width_err), 32'(eErr));
        checkOutput({tag, "_count"}, 32'(vid.frame_count), 32'(16'(expCount)));
        applyStimulus(1'b1, 1'b0, 1'b1, 24'h0);
        checkOutput({tag, "_valid_low"}, 32'(vid.frame_valid), 32'd0);
        checkOutput({tag, "_crc_hold"},  vid.frame_crc, eCrc);
        blankTail();
    endtask

    task automatic sendFrame(input frameVec_t v, output logic [31:0] crcOut);
        int          pixIdx;
        int          w;
        logic [23:0] px;
        pixIdx = 0;
        crcOut = 32'hFFFFFFFF;
        for (int l = 0; l < v.lines; l++) begin
            w = (l == 0) ? v.w0 : ((l == 1) ? v.w1 : v.w2);
            for (int k = 0; k < w; k++) begin
                px = pixVal(pixIdx, v.flip && (pixIdx == 2));
                crcOut = modelCrc(crcOut, px);
                sendPixel(px, v.gap);
                pixIdx++;
            end
            if (!(v.joinVb && (l == v.lines - 1)))
                applyStimulus(1'b1, 1'b1, 1'b0, 24'h0);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        pubCount = 0;
        expCount = 0;
        refCrc   = 32'hFFFFFFFF;

        //            lines w0 w1 w2 gap flip join  W  H err
        vecs[0] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[1] = '{3, 4, 4, 4, 0, 0, 0, 4, 3, 0};
        vecs[2] = '{3, 4, 4, 4, 1, 0, 0, 4, 3, 0};
        vecs[3] = '{3, 4, 4, 5, 0, 0, 0, 4, 3, 1};
        vecs[4] = '{3, 4, 4, 4, 0, 0, 0, 4, 3, 0};
        vecs[5] = '{3, 4, 4, 4, 0, 1, 0, 4, 3, 0};
        vecs[6] = '{2, 5, 5, 0, 0, 0, 1, 5, 2, 0};
        vecs[7] = '{3, 1, 1, 1, 0, 0, 0, 1, 3, 0};
        vecs[8] = '{2, 3, 5, 0, 0, 0, 1, 3, 2, 1};

        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b1, 24'h0);
        checkOutput("reset_valid", 32'(vid.frame_valid), 32'd0);
        checkOutput("reset_crc",   vid.frame_crc, 32'd0);
        checkOutput("reset_w",     32'(vid.active_w), 32'd0);
        checkOutput("reset_h",     32'(vid.active_h), 32'd0);
        checkOutput("reset_err",   32'(vid.width_err), 32'd0);
        checkOutput("reset_count", 32'(vid.frame_count), 32'd0);
        reset_n  = 1'b1;
        pubCount = 0;

        applyStimulus(1'b1, 1'b1, 1'b0, 24'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 24'h0);
        alignFrame("start");

        for (int i = 0; i < 9; i++) begin
            sendFrame(vecs[i], crcM);
            if (i == 1) refCrc = crcM;
            endFrame($sformatf("vec%0d", i), crcM, vecs[i].expW, vecs[i].expH, vecs[i].expErr);
            if (vecs[i].flip) checkDiffer($sformatf("vec%0d_crc_changed", i), vid.frame_crc, refCrc);
            if (i == 0) checkOutput("empty_crc_const", vid.frame_crc, 32'hFFFFFFFF);
        end
        checkOutput("table_pub_count", 32'(pubCount), 32'(expCount));

        // "123456789" as three pixels gives the published CRC-32/MPEG-2 check value.
        sendPixel(24'h313233, 1'b0);
        sendPixel(24'h343536, 1'b0);
        sendPixel(24'h373839, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 24'h0);
        endFrame("known", 32'h0376E6E7, 3, 1, 0);

        $display("[TB] mid-frame reset sequence");
        sendPixel(24'h0A0B0C, 1'b0);
        sendPixel(24'h0D0E0F, 1'b0);
        reset_n = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 24'h111111);
        applyStimulus(1'b1, 1'b0, 1'b1, 24'h0);
        checkOutput("midrst_valid", 32'(vid.frame_valid), 32'd0);
        checkOutput("midrst_count", 32'(vid.frame_count), 32'd0);
        checkOutput("midrst_crc",   vid.frame_crc, 32'd0);
        reset_n  = 1'b1;
        pubCount = 0;
        expCount = 0;
        sendPixel(24'h222222, 1'b0);
        sendPixel(24'h333333, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 24'h0);
        alignFrame("midrst");
        crcM = 32'hFFFFFFFF;
        for (int l = 0; l < 2; l++) begin
            for (int k = 0; k < 2; k++) begin
                crcM = modelCrc(crcM, pixVal(l * 2 + k, 1'b0));
                sendPixel(pixVal(l * 2 + k, 1'b0), 1'b0);
            end
            applyStimulus(1'b1, 1'b1, 1'b0, 24'h0);
        end
        endFrame("midrst_frame", crcM, 2, 2, 0);
        checkOutput("midrst_pub_count", 32'(pubCount), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
